video_stream_tx: RTL
====================

Name: video_stream_tx

Overview:
Transmitter side of the team's vs/de/data video stream: this block generates that stream, and the existing filter chains consume it.
- Reads pixels from an upstream standard-read-latency FIFO (one-cycle read latency, not first-word-fall-through).
- Emits frames of COL x ROW pixels with vertical sync, back porch, front porch and horizontal blanking.
- Output timing is defined so that the rising edge of o_vs cleanly resets downstream matrix and filter stages.
- Sits between a frame buffer or DDR read FIFO and the vip processing chain.

Parameters:
COL, 640, active pixels per line
ROW, 480, active lines per frame
DW, 8, pixel data width
H_BLANK, 160, idle cycles after each line's active pixels (>=1)
VS_LINES, 2, lines with vs high (>=1)
V_BP, 33, back-porch lines after vs (>=1)
V_FP, 10, front-porch lines after the last active line (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run request; sampled only at frame boundaries
fifo_empty  in  1  upstream FIFO empty flag
fifo_dout  in  DW  upstream FIFO read data, valid one cycle after fifo_rd_en
fifo_rd_en  out  1  FIFO read strobe
o_vs  out  1  frame sync, active high
o_de  out  1  pixel valid
o_data  out  DW  pixel data; 0 whenever o_de=0
frame_done  out  1  one-cycle pulse at the end of every frame
underflow  out  1  sticky flag: FIFO was empty on a read in the current frame

Behaviour:
- Reset is synchronous and active-low on rst_n; clock is clk.
- Reset values: state=IDLE, all counters 0, fifo_rd_en=0, o_vs=0, o_de=0, o_data=0, frame_done=0, underflow=0.
- Reset mid-frame aborts immediately. The next frame starts from VSYNC only after a fresh enable.
- Line length LINE = COL + H_BLANK cycles. h_cnt counts 0..LINE-1 and wraps. v_cnt counts lines within the current state.
- FSM states and transitions:
  - IDLE -> VSYNC when enable=1; h_cnt=0, v_cnt=0.
  - VSYNC: VS_LINES lines -> VBP.
  - VBP: V_BP lines -> ACTIVE.
  - ACTIVE: ROW lines -> VFP.
  - VFP: V_FP lines -> VSYNC if enable=1, else IDLE.
  - State changes happen only at h_cnt=LINE-1 of the last line of a state. v_cnt clears on each state change.
- enable deasserted mid-frame: the current frame completes fully; enable is re-sampled at the end of VFP.
- fifo_rd_en is a decode of registered state: ACTIVE and h_cnt<COL. It is high for exactly COL consecutive cycles per active line.
- Output pipeline, one register stage:
  - o_de(t+1) = fifo_rd_en(t).
  - o_vs(t+1) = (state==VSYNC)(t).
  - o_data(t+1) = fifo_dout if o_de, else 0.
  - Net effect: o_vs and o_de stay aligned with each other, each one cycle behind the internal state.
- Underflow:
  - fifo_rd_en=1 with fifo_empty=1 -> the corresponding output pixel is 0x00 and o_de stays 1, so stream geometry is never broken.
  - underflow is set on that same output cycle and holds until the next entry into VSYNC, where it clears.
  - Simultaneous clear and new underflow cannot occur, because no reads happen in VSYNC.
- frame_done pulses for one cycle on the cycle after the final VFP cycle, i.e. the first cycle of the next VSYNC or IDLE.
- Counter widths are $clog2 of their maximum counts. No arithmetic overflow is possible for legal parameters.
- Frame period = (VS_LINES + V_BP + ROW + V_FP) * LINE cycles.

Test Plan:
All scenarios use COL=4, ROW=3, H_BLANK=2, VS_LINES=1, V_BP=1, V_FP=1, DW=8. LINE=6; frame period 36 cycles.
1. Basic frame: enable=1 at cycle T in IDLE, FIFO holding 1..12 -> o_vs=1 for cycles T+2..T+7; fifo_rd_en at T+13..T+16; o_de at T+14..T+17 with data 1,2,3,4; o_de pattern 4 on / 2 off for 3 lines; frame_done pulse at T+37.
2. Continuous: enable held -> second o_vs rise at T+38; exactly 12 o_de cycles per 36-cycle frame; no gaps or extra reads.
3. Enable drop: enable=0 during ACTIVE -> frame completes, frame_done at T+37, state IDLE, o_vs stays 0 afterwards.
4. Underflow: fifo_empty=1 during the 2nd read of line 0 -> that pixel is 0x00 with o_de=1; underflow=1 from that cycle; cleared on the next VSYNC entry.
5. Reset mid-frame: rst_n=0 during ACTIVE -> next edge all outputs 0 and state IDLE; no fifo_rd_en until enable is sampled again.
6. Blanking data: o_data=0 on every cycle with o_de=0, including during o_vs.

Source files
------------

// File: rtl/video_stream_tx.sv
// vs/de/data video stream transmitter: pulls pixels from a one-cycle-latency FIFO
// and frames them with vsync, back porch, active lines, front porch and h-blanking.
module video_stream_tx #(
    parameter int COL      = 640,
    parameter int ROW      = 480,
    parameter int DW       = 8,
    parameter int H_BLANK  = 160,
    parameter int VS_LINES = 2,
    parameter int V_BP     = 33,
    parameter int V_FP     = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd_en,
    output logic          o_vs,
    output logic          o_de,
    output logic [DW-1:0] o_data,
    output logic          frame_done,
    output logic          underflow
);

    localparam int LINE  = COL + H_BLANK;
    localparam int VMAX0 = (VS_LINES > V_BP) ? VS_LINES : V_BP;
    localparam int VMAX1 = (ROW > V_FP) ? ROW : V_FP;
    localparam int VMAX  = (VMAX0 > VMAX1) ? VMAX0 : VMAX1;
    localparam int HW    = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int VW    = (VMAX > 1) ? $clog2(VMAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [VW-1:0] last_v;
    logic          line_end;
    logic          last_line;
    logic          frame_end;
    logic          vsync_entry;
    logic          o_de_q;
    logic          o_vs_q;
    logic          hole_q;
    logic          frame_done_q;
    logic          underflow_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        last_v  = '0;

        unique case (state_q)
            VSYNC:   last_v = VW'(VS_LINES - 1);
            VBP:     last_v = VW'(V_BP - 1);
            ACTIVE:  last_v = VW'(ROW - 1);
            VFP:     last_v = VW'(V_FP - 1);
            default: last_v = '0;
        endcase

        line_end  = (h_cnt_q == HW'(LINE - 1));
        last_line = (v_cnt_q == last_v);

        if (state_q == IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (enable) state_d = VSYNC;
        end else begin
            h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
            if (line_end) begin
                if (last_line) begin
                    v_cnt_d = '0;
                    unique case (state_q)
                        VSYNC:   state_d = VBP;
                        VBP:     state_d = ACTIVE;
                        ACTIVE:  state_d = VFP;
                        VFP:     state_d = enable ? VSYNC : IDLE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end
        end

        frame_end   = (state_q == VFP) && line_end && last_line;
        vsync_entry = (state_d == VSYNC) && (state_q != VSYNC);
    end

    // Read strobe decoded straight from registered state, so it is glitch-free per cycle.
    assign fifo_rd_en = (state_q == ACTIVE) && (h_cnt_q < HW'(COL));

    // NOTE: reset is synchronous here, so rst_n is tested inside the clocked branch only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            o_de_q       <= 1'b0;
            o_vs_q       <= 1'b0;
            hole_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            o_de_q       <= fifo_rd_en;
            o_vs_q       <= (state_q == VSYNC);
            hole_q       <= fifo_rd_en && fifo_empty;
            frame_done_q <= frame_end;
            if (vsync_entry)
                underflow_q <= 1'b0;
            else if (fifo_rd_en && fifo_empty)
                underflow_q <= 1'b1;
        end
    end

    // FIFO data arrives one cycle after the strobe, already aligned with o_de; only gate it.
    assign o_data     = (o_de_q && !hole_q) ? fifo_dout : '0;
    assign o_de       = o_de_q;
    assign o_vs       = o_vs_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

endmodule
